// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: op codes, flag bit positions,
// output-queue entry layout and the masked flag-merge helper.
package exec_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_PASS_B = 4'd5;
  localparam logic [3:0] OP_SHL    = 4'd6;
  localparam logic [3:0] OP_SHR    = 4'd7;
  localparam logic [3:0] OP_MUL    = 4'd8;

  localparam int unsigned FLAG_CF = 0;
  localparam int unsigned FLAG_ZF = 1;
  localparam int unsigned FLAG_SF = 2;
  localparam int unsigned FLAG_OF = 3;
  localparam int unsigned FLAG_DF = 4;
  localparam int unsigned FLAGS_W = 5;

  // Queue entry packs {illegal, flags, result_hi, result, tag}, MSB first
  function automatic int unsigned entry_width(input int unsigned data_w,
                                              input int unsigned tag_w);
    return 1 + FLAGS_W + 2 * data_w + tag_w;
  endfunction

  function automatic logic [FLAGS_W-1:0] merge_flags(
      input logic [FLAGS_W-1:0] old_flags,
      input logic [3:0]         mask,
      input logic [3:0]         new_flags,
      input logic               wr_en,
      input logic               set_d,
      input logic               clr_d);
    logic [FLAGS_W-1:0] f;
    f = old_flags;
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) f[i] = new_flags[i];
      end
    end
    if (set_d)      f[FLAG_DF] = 1'b1;
    else if (clr_d) f[FLAG_DF] = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/exec_stage_q_if.sv
// Issue-side and writeback-side handshake bundle of the execute stage.
interface exec_stage_q_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 48
);
  logic              e_valid;
  logic              e_ready;
  logic [3:0]        e_op;
  logic [DATA_W-1:0] e_op_a;
  logic [DATA_W-1:0] e_op_b;
  logic [TAG_W-1:0]  e_tag;
  logic [3:0]        e_flag_mask;
  logic              e_set_d_flag;
  logic              e_clear_d_flag;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_result;
  logic [DATA_W-1:0] wb_result_hi;
  logic [TAG_W-1:0]  wb_tag;
  logic [4:0]        wb_flags;
  logic              wb_illegal;

  modport master (
    output e_valid, e_op, e_op_a, e_op_b, e_tag, e_flag_mask,
           e_set_d_flag, e_clear_d_flag, wb_ready,
    input  e_ready, wb_valid, wb_result, wb_result_hi, wb_tag, wb_flags, wb_illegal
  );

  modport slave (
    input  e_valid, e_op, e_op_a, e_op_b, e_tag, e_flag_mask,
           e_set_d_flag, e_clear_d_flag, wb_ready,
    output e_ready, wb_valid, wb_result, wb_result_hi, wb_tag, wb_flags, wb_illegal
  );
endinterface

// File: rtl/exec_out_fifo.sv
// In-order synchronous FIFO with occupancy count and synchronous clear.
// Read data is forced to zero while empty.
module exec_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
  assign o_rdata   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/exec_stage_q.sv
// Execute stage: single-cycle ALU, optional iterative multiplier (EXEC_MUL_EN),
// architectural flags register and an in-order output queue ahead of writeback.
module exec_stage_q
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 48,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  exec_stage_q_if.slave       bus,
  output logic [FLAGS_W-1:0]  eflags_out
);
  localparam int unsigned SH_W    = $clog2(DATA_W);
  localparam int unsigned CNT_W   = $clog2(OUT_DEPTH + 1);
  localparam int unsigned ENTRY_W = entry_width(DATA_W, TAG_W);
  localparam int unsigned MSB     = DATA_W - 1;

  logic [FLAGS_W-1:0] r_flags;
  logic               w_idle;
  logic               w_accept;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_rdata;

  logic [DATA_W:0]    w_add, w_sub, w_shl, w_shr;
  logic [SH_W-1:0]    w_sh;
  logic [DATA_W-1:0]  w_res;
  logic               w_cf, w_of, w_wr, w_ill, w_is_mul;

  logic [DATA_W-1:0]  w_c_res, w_c_hi;
  logic [TAG_W-1:0]   w_c_tag;
  logic [3:0]         w_c_mask, w_newf;
  logic               w_c_cf, w_c_of, w_c_wr, w_c_ill, w_c_setd, w_c_clrd, w_push;
  logic [FLAGS_W-1:0] w_c_flags;

  assign bus.e_ready = !reset && w_idle && (w_count < CNT_W'(OUT_DEPTH));
  assign w_accept    = bus.e_valid && bus.e_ready && !flush;
  assign w_sh        = bus.e_op_b[SH_W-1:0];

  // Single-cycle ALU; shifts carry the last bit out through an extra position
  always_comb begin
    w_add    = {1'b0, bus.e_op_a} + {1'b0, bus.e_op_b};
    w_sub    = {1'b0, bus.e_op_a} - {1'b0, bus.e_op_b};
    w_shl    = {1'b0, bus.e_op_a} << w_sh;
    w_shr    = {bus.e_op_a, 1'b0} >> w_sh;
    w_res    = '0;
    w_cf     = 1'b0;
    w_of     = 1'b0;
    w_wr     = 1'b0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    case (bus.e_op)
      OP_ADD: begin
        w_res = w_add[DATA_W-1:0];
        w_cf  = w_add[DATA_W];
        w_of  = (bus.e_op_a[MSB] == bus.e_op_b[MSB]) && (w_res[MSB] != bus.e_op_a[MSB]);
        w_wr  = 1'b1;
      end
      OP_SUB: begin
        w_res = w_sub[DATA_W-1:0];
        w_cf  = w_sub[DATA_W];
        w_of  = (bus.e_op_a[MSB] != bus.e_op_b[MSB]) && (w_res[MSB] != bus.e_op_a[MSB]);
        w_wr  = 1'b1;
      end
      OP_AND:    begin w_res = bus.e_op_a & bus.e_op_b; w_wr = 1'b1; end
      OP_OR:     begin w_res = bus.e_op_a | bus.e_op_b; w_wr = 1'b1; end
      OP_XOR:    begin w_res = bus.e_op_a ^ bus.e_op_b; w_wr = 1'b1; end
      OP_PASS_B: w_res = bus.e_op_b;
      OP_SHL: begin
        w_res = w_shl[DATA_W-1:0];
        w_cf  = w_shl[DATA_W];
        w_wr  = (w_sh != '0);
      end
      OP_SHR: begin
        w_res = w_shr[DATA_W:1];
        w_cf  = w_shr[0];
        w_wr  = (w_sh != '0);
      end
`ifdef EXEC_MUL_EN
      OP_MUL:    w_is_mul = 1'b1;
`endif
      default:   w_ill = 1'b1;
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [0:0] { S_IDLE, S_BUSY } state_t;

  state_t              r_state;
  logic [2*DATA_W-1:0] r_prod;
  logic [DATA_W-1:0]   r_mcand;
  logic [SH_W-1:0]     r_step;
  logic [TAG_W-1:0]    r_tag;
  logic [3:0]          r_mask;
  logic                r_setd, r_clrd;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_prod_nx;
  logic                w_mul_last;

  assign w_idle     = (r_state == S_IDLE);
  assign w_sum      = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nx  = {w_sum, r_prod[DATA_W-1:1]};
  assign w_mul_last = (r_state == S_BUSY) && (r_step == SH_W'(DATA_W - 1));

  // Shift-add multiplier: multiplier sits in the low half and shifts out LSB first
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= S_IDLE;
      r_prod  <= '0;
      r_mcand <= '0;
      r_step  <= '0;
      r_tag   <= '0;
      r_mask  <= '0;
      r_setd  <= 1'b0;
      r_clrd  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && w_is_mul) begin
          r_state <= S_BUSY;
          r_prod  <= {{DATA_W{1'b0}}, bus.e_op_b};
          r_mcand <= bus.e_op_a;
          r_step  <= '0;
          r_tag   <= bus.e_tag;
          r_mask  <= bus.e_flag_mask;
          r_setd  <= bus.e_set_d_flag;
          r_clrd  <= bus.e_clear_d_flag;
        end
        S_BUSY: begin
          r_prod <= w_prod_nx;
          r_step <= r_step + 1'b1;
          if (w_mul_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_idle = 1'b1;
`endif

  // Commit source: the presented single-cycle op, or the finishing multiply
  always_comb begin
    w_c_res  = w_res;
    w_c_hi   = '0;
    w_c_cf   = w_cf;
    w_c_of   = w_of;
    w_c_wr   = w_wr;
    w_c_ill  = w_ill;
    w_c_tag  = bus.e_tag;
    w_c_mask = bus.e_flag_mask;
    w_c_setd = bus.e_set_d_flag;
    w_c_clrd = bus.e_clear_d_flag;
    w_push   = w_accept && !w_is_mul;
`ifdef EXEC_MUL_EN
    if (w_mul_last) begin
      w_c_res  = w_prod_nx[DATA_W-1:0];
      w_c_hi   = w_prod_nx[2*DATA_W-1:DATA_W];
      w_c_cf   = (w_c_hi != '0);
      w_c_of   = (w_c_hi != '0);
      w_c_wr   = 1'b1;
      w_c_ill  = 1'b0;
      w_c_tag  = r_tag;
      w_c_mask = r_mask;
      w_c_setd = r_setd;
      w_c_clrd = r_clrd;
      w_push   = !flush;
    end
`endif
    w_newf          = '0;
    w_newf[FLAG_CF] = w_c_cf;
    w_newf[FLAG_ZF] = (w_c_res == '0);
    w_newf[FLAG_SF] = w_c_res[MSB];
    w_newf[FLAG_OF] = w_c_of;
    w_c_flags = w_c_ill ? r_flags
                        : merge_flags(r_flags, w_c_mask, w_newf, w_c_wr, w_c_setd, w_c_clrd);
  end

  always_ff @(posedge clk) begin
    if (reset)       r_flags <= '0;
    else if (w_push) r_flags <= w_c_flags;
  end

  assign eflags_out = r_flags;

  exec_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (flush),
    .i_push  (w_push),
    .i_wdata ({w_c_ill, w_c_flags, w_c_hi, w_c_res, w_c_tag}),
    .i_pop   (bus.wb_valid && bus.wb_ready),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  assign bus.wb_valid     = (w_count != '0);
  assign bus.wb_tag       = w_rdata[TAG_W-1:0];
  assign bus.wb_result    = w_rdata[TAG_W +: DATA_W];
  assign bus.wb_result_hi = w_rdata[TAG_W+DATA_W +: DATA_W];
  assign bus.wb_flags     = w_rdata[TAG_W+2*DATA_W +: FLAGS_W];
  assign bus.wb_illegal   = w_rdata[ENTRY_W-1];
endmodule

// File: tb/tb_exec_stage_q.sv
// Directed self-checking bench for exec_stage_q (DATA_W=32, TAG_W=48, OUT_DEPTH=4);
// the multiply checks follow whether EXEC_MUL_EN is defined.
module tb_exec_stage_q;
  import exec_pkg::*;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [4:0] eflags_out;
  int         n_cmp;
  int         n_err;

  exec_stage_q_if #(.DATA_W(32), .TAG_W(48)) bus ();

  exec_stage_q #(.DATA_W(32), .TAG_W(48), .OUT_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .eflags_out (eflags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op and hold it until accepted; returns at accept edge + 1.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [47:0] tag, input logic [3:0] mask,
                      input logic sd, input logic cd);
    int n;
    n = 0;
    bus.e_op = op; bus.e_op_a = a; bus.e_op_b = b; bus.e_tag = tag;
    bus.e_flag_mask = mask; bus.e_set_d_flag = sd; bus.e_clear_d_flag = cd;
    bus.e_valid = 1'b1;
    @(negedge clk);
    while (!bus.e_ready && n < 60) begin @(negedge clk); n++; end
    if (!bus.e_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: e_ready stayed %0b, want 1", bus.e_ready);
    end
    @(posedge clk); #1;
    bus.e_valid = 1'b0; bus.e_set_d_flag = 1'b0; bus.e_clear_d_flag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; bus.wb_ready = 1'b1;
    bus.e_valid = 1'b1; bus.e_op = OP_ADD; bus.e_op_a = 32'd1; bus.e_op_b = 32'd1;
    bus.e_tag = '0; bus.e_flag_mask = 4'hF; bus.e_set_d_flag = 1'b0; bus.e_clear_d_flag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.e_ready !== 1'b0) begin n_err++; $display("FAIL reset_e_ready: got %0b want 0", bus.e_ready); end
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %0b want 0", bus.wb_valid); end
    n_cmp++; if (eflags_out !== 5'b0) begin n_err++; $display("FAIL reset_eflags: got %b want 00000", eflags_out); end
    n_cmp++; if (bus.wb_result !== 32'd0) begin n_err++; $display("FAIL reset_wb_result: got %h want 0", bus.wb_result); end
    bus.e_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.e_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_e_ready: got %0b want 1", bus.e_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 48'hA1, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %0b want 1", bus.wb_valid); end
    n_cmp++; if (bus.wb_result !== 32'd0) begin n_err++; $display("FAIL add_result: got %h want 0", bus.wb_result); end
    n_cmp++; if (bus.wb_flags !== 5'b00011) begin n_err++; $display("FAIL add_flags: got %b want 00011", bus.wb_flags); end
    n_cmp++; if (bus.wb_tag !== 48'hA1) begin n_err++; $display("FAIL add_tag: got %h want a1", bus.wb_tag); end
    n_cmp++; if (bus.wb_result_hi !== 32'd0) begin n_err++; $display("FAIL add_hi: got %h want 0", bus.wb_result_hi); end
    n_cmp++; if (eflags_out !== 5'b00011) begin n_err++; $display("FAIL add_eflags: got %b want 00011", eflags_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    send(OP_SUB, 32'd5, 32'd7, 48'hB2, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.wb_result !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_result: got %h want fffffffe", bus.wb_result); end
    n_cmp++; if (bus.wb_flags !== 5'b00101) begin n_err++; $display("FAIL sub_flags: got %b want 00101", bus.wb_flags); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int k;
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 48'hC3, 4'hF, 1'b0, 1'b0);
`ifdef EXEC_MUL_EN
    k = 0;
    @(negedge clk); k = 1;
    n_cmp++; if (bus.e_ready !== 1'b0) begin n_err++; $display("FAIL mul_busy_ready: got %0b want 0", bus.e_ready); end
    while (!bus.wb_valid && k < 40) begin @(negedge clk); k++; end
    n_cmp++; if (k !== 33) begin n_err++; $display("FAIL mul_latency: got %0d want 33", k); end
    n_cmp++; if (bus.wb_result !== 32'd0) begin n_err++; $display("FAIL mul_lo: got %h want 0", bus.wb_result); end
    n_cmp++; if (bus.wb_result_hi !== 32'd1) begin n_err++; $display("FAIL mul_hi: got %h want 1", bus.wb_result_hi); end
    n_cmp++; if (bus.wb_flags !== 5'b01011) begin n_err++; $display("FAIL mul_flags: got %b want 01011", bus.wb_flags); end
`else
    k = 0;
    @(negedge clk);
    n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL mul_off_valid: got %0b want 1", bus.wb_valid); end
    n_cmp++; if (bus.wb_illegal !== 1'b1) begin n_err++; $display("FAIL mul_off_illegal: got %0b want 1", bus.wb_illegal); end
    n_cmp++; if (bus.wb_result !== 32'd0) begin n_err++; $display("FAIL mul_off_result: got %h want 0", bus.wb_result); end
    n_cmp++; if (bus.wb_flags !== 5'b00101) begin n_err++; $display("FAIL mul_off_flags: got %b want 00101", bus.wb_flags); end
    n_cmp++; if (eflags_out !== 5'b00101) begin n_err++; $display("FAIL mul_off_eflags: got %b want 00101", eflags_out); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    bus.wb_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.e_op = OP_ADD; bus.e_op_a = 32'(i); bus.e_op_b = 32'd0; bus.e_tag = 48'(i);
      bus.e_flag_mask = 4'h0; bus.e_valid = 1'b1;
      @(negedge clk);
      if (bus.e_ready) acc++;
      if (i < 5) begin @(posedge clk); #1; end
    end
    n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    n_cmp++; if (bus.e_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %0b want 0", bus.e_ready); end
    @(posedge clk); #1;
    bus.wb_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_tag !== 48'(j) || bus.wb_result !== 32'(j)) begin
        n_err++; $display("FAIL bp_drain_%0d: got valid %0b tag %0d result %0d want 1 %0d %0d",
                          j, bus.wb_valid, bus.wb_tag, bus.wb_result, j, j);
      end
      if (j == 1) begin
        n_cmp++; if (bus.e_ready !== 1'b0) begin n_err++; $display("FAIL bp_pop_full_ready: got %0b want 0", bus.e_ready); end
      end
      if (j == 2) begin
        n_cmp++; if (bus.e_ready !== 1'b1) begin n_err++; $display("FAIL bp_fifth_ready: got %0b want 1", bus.e_ready); end
      end
      @(posedge clk); #1;
      if (j == 2) bus.e_valid = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %0b want 0", bus.wb_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_queue();
    bus.wb_ready = 1'b0;
    send(OP_ADD, 32'd0, 32'd0, 48'h7, 4'hF, 1'b0, 1'b0);
    bus.e_op = OP_SUB; bus.e_op_a = 32'd0; bus.e_op_b = 32'd1; bus.e_tag = 48'h8;
    bus.e_flag_mask = 4'hF; bus.e_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus.e_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL flushq_valid: got %0b want 0", bus.wb_valid); end
    n_cmp++; if (bus.e_ready !== 1'b1) begin n_err++; $display("FAIL flushq_ready: got %0b want 1", bus.e_ready); end
    n_cmp++; if (eflags_out !== 5'b00010) begin n_err++; $display("FAIL flushq_eflags: got %b want 00010", eflags_out); end
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_flags();
    logic [3:0]  v_op   [7];
    logic [31:0] v_a    [7];
    logic [31:0] v_b    [7];
    logic [3:0]  v_mask [7];
    logic        v_sd   [7];
    logic        v_cd   [7];
    logic [31:0] v_res  [7];
    logic [4:0]  v_fl   [7];
    logic        v_ill  [7];
    v_op[0]=OP_PASS_B; v_a[0]=32'd0;          v_b[0]=32'hDEAD; v_mask[0]=4'h0; v_sd[0]=1; v_cd[0]=1; v_res[0]=32'hDEAD; v_fl[0]=5'b10010; v_ill[0]=0;
    v_op[1]=OP_PASS_B; v_a[1]=32'd0;          v_b[1]=32'd0;    v_mask[1]=4'h0; v_sd[1]=0; v_cd[1]=1; v_res[1]=32'd0;    v_fl[1]=5'b00010; v_ill[1]=0;
    v_op[2]=OP_SHL;    v_a[2]=32'h1234;       v_b[2]=32'h20;   v_mask[2]=4'hF; v_sd[2]=0; v_cd[2]=0; v_res[2]=32'h1234; v_fl[2]=5'b00010; v_ill[2]=0;
    v_op[3]=OP_SHL;    v_a[3]=32'h8000_0001;  v_b[3]=32'd1;    v_mask[3]=4'hF; v_sd[3]=0; v_cd[3]=0; v_res[3]=32'd2;    v_fl[3]=5'b00001; v_ill[3]=0;
    v_op[4]=OP_SHR;    v_a[4]=32'h18;         v_b[4]=32'd4;    v_mask[4]=4'hF; v_sd[4]=0; v_cd[4]=0; v_res[4]=32'd1;    v_fl[4]=5'b00001; v_ill[4]=0;
    v_op[5]=OP_AND;    v_a[5]=32'hF0;         v_b[5]=32'h0F;   v_mask[5]=4'hF; v_sd[5]=0; v_cd[5]=0; v_res[5]=32'd0;    v_fl[5]=5'b00010; v_ill[5]=0;
    v_op[6]=4'd12;     v_a[6]=32'd5;          v_b[6]=32'd6;    v_mask[6]=4'hF; v_sd[6]=0; v_cd[6]=0; v_res[6]=32'd0;    v_fl[6]=5'b00010; v_ill[6]=1;
    for (int i = 0; i < 7; i++) begin
      send(v_op[i], v_a[i], v_b[i], 48'(16 + i), v_mask[i], v_sd[i], v_cd[i]);
      @(negedge clk);
      n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_result !== v_res[i] || bus.wb_illegal !== v_ill[i]) begin
        n_err++; $display("FAIL alu_%0d_result: got valid %0b result %h illegal %0b want 1 %h %0b",
                          i, bus.wb_valid, bus.wb_result, bus.wb_illegal, v_res[i], v_ill[i]);
      end
      n_cmp++; if (bus.wb_flags !== v_fl[i]) begin n_err++; $display("FAIL alu_%0d_flags: got %b want %b", i, bus.wb_flags, v_fl[i]); end
      n_cmp++; if (eflags_out !== v_fl[i]) begin n_err++; $display("FAIL alu_%0d_eflags: got %b want %b", i, eflags_out, v_fl[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul_flush();
`ifdef EXEC_MUL_EN
    int seen;
    send(OP_MUL, 32'd3, 32'd5, 48'hD4, 4'hF, 1'b0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.e_ready !== 1'b1) begin n_err++; $display("FAIL mulflush_ready: got %0b want 1", bus.e_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wb_valid) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mulflush_valid: got %0d valid cycles want 0", seen); end
    n_cmp++; if (eflags_out !== 5'b00010) begin n_err++; $display("FAIL mulflush_eflags: got %b want 00010", eflags_out); end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_flush_queue();
    test_alu_flags();
    test_mul_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
